// File: rtl/interval_timer_if.sv
// Handshake bundle between the program/sync block, the traffic FSM and the interval timer.
// start_timer is a one-cycle request with no ready; expired is a level that acts as the timer's
// "valid" and stays high from interval end until the next start_timer.
interface interval_timer_if #(
    parameter int VALUE_W = 4
);
    logic               prg_sync_in;
    logic [1:0]         param_sel;
    logic [VALUE_W-1:0] time_value;
    logic               start_timer;
    logic [1:0]         interval_address;
    logic               expired;
    logic [VALUE_W-1:0] remaining;
    logic               tick_1hz;

    modport master (
        output prg_sync_in, param_sel, time_value, start_timer, interval_address,
        input  expired, remaining, tick_1hz
    );

    modport slave (
        input  prg_sync_in, param_sel, time_value, start_timer, interval_address,
        output expired, remaining, tick_1hz
    );
endinterface

// File: rtl/interval_timer.sv
// Programmable interval timer: three interval registers, a one-second prescaler and a
// seconds countdown that raises expired at interval end until the FSM restarts it.
module interval_timer #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int VALUE_W       = 4,
    parameter int BASE_DEF      = 6,
    parameter int EXT_DEF       = 3,
    parameter int YEL_DEF       = 2
) (
    input  logic             clk,
    input  logic             sys_reset_n,
    interval_timer_if.slave  bus,
    output logic             dbg_state
);
    localparam int PRESC_W = $clog2(TICKS_PER_SEC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    typedef enum logic {RUNNING = 1'b0, EXPIRED = 1'b1} state_t;

    state_t             state;
    logic [PRESC_W-1:0] presc;
    logic [VALUE_W-1:0] base_q;
    logic [VALUE_W-1:0] ext_q;
    logic [VALUE_W-1:0] yel_q;
    logic [VALUE_W-1:0] remaining_q;
    logic               expired_q;
    logic               tick_q;
    logic               wr_en;
    logic [1:0]         load_addr;
    logic [VALUE_W-1:0] load_val;

    // Zero writes are dropped so an interval can never be programmed to nothing.
    assign wr_en     = bus.prg_sync_in && (bus.param_sel != 2'b11) && (bus.time_value != '0);
    assign load_addr = (bus.interval_address == 2'b11) ? 2'b00 : bus.interval_address;

    always_comb begin
        load_val = base_q;
        case (load_addr)
            2'b01:   load_val = ext_q;
            2'b10:   load_val = yel_q;
            default: load_val = base_q;
        endcase
        // A same-edge write to the register being loaded is forwarded.
        if (wr_en && (bus.param_sel == load_addr)) begin
            load_val = bus.time_value;
        end
    end

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state       <= RUNNING;
            presc       <= '0;
            base_q      <= VALUE_W'(BASE_DEF);
            ext_q       <= VALUE_W'(EXT_DEF);
            yel_q       <= VALUE_W'(YEL_DEF);
            remaining_q <= VALUE_W'(BASE_DEF);
            expired_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (wr_en) begin
                case (bus.param_sel)
                    2'b00:   base_q <= bus.time_value;
                    2'b01:   ext_q  <= bus.time_value;
                    2'b10:   yel_q  <= bus.time_value;
                    default: ;
                endcase
            end
            if (bus.start_timer) begin
                state       <= RUNNING;
                remaining_q <= load_val;
                presc       <= '0;
                expired_q   <= 1'b0;
            end else if (state == RUNNING) begin
                if (presc == PRESC_LAST) begin
                    presc  <= '0;
                    tick_q <= 1'b1;
                    if (remaining_q != '0) begin
                        remaining_q <= remaining_q - VALUE_W'(1);
                    end
                    if (remaining_q <= VALUE_W'(1)) begin
                        state     <= EXPIRED;
                        expired_q <= 1'b1;
                    end
                end else begin
                    presc <= presc + PRESC_W'(1);
                end
            end
        end
    end

    assign bus.expired   = expired_q;
    assign bus.remaining = remaining_q;
    assign bus.tick_1hz  = tick_q;
    assign dbg_state     = (state == EXPIRED);
endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with TICKS_PER_SEC=4: expiry edges are scored against
// an expected queue filled by the stimulus, plus direct checks of reset and display values.
module tb_interval_timer;
    localparam int T = 4;
    localparam int W = 4;

    logic clk;
    logic sys_reset_n;
    logic dbg_state;
    int   cyc;
    int   total;
    int   bad;
    logic prev_exp;
    logic [31:0] exp_q[$];

    interval_timer_if #(.VALUE_W(W)) bus ();

    interval_timer #(
        .TICKS_PER_SEC(T), .VALUE_W(W), .BASE_DEF(6), .EXT_DEF(3), .YEL_DEF(2)
    ) dut (
        .clk(clk), .sys_reset_n(sys_reset_n), .bus(bus), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every rising edge of expired must match the head of the expected queue
    always @(negedge clk) begin
        if (sys_reset_n && bus.expired && !prev_exp) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_expiry: rose at cycle %0d, none expected", cyc);
            end else begin
                check("expiry_cycle", cyc, int'(exp_q.pop_front()));
            end
        end
        prev_exp <= bus.expired;
    end

    // driver: one cycle of program and/or start; a start supersedes any pending expiry
    task automatic drive(input logic prg, input logic [1:0] psel, input logic [W-1:0] val,
                         input logic st, input logic [1:0] addr, input int n_sec);
        @(negedge clk);
        bus.prg_sync_in      = prg;
        bus.param_sel        = psel;
        bus.time_value       = val;
        bus.start_timer      = st;
        bus.interval_address = addr;
        if (st) begin
            exp_q.delete();
            exp_q.push_back(32'(cyc + 1 + n_sec * T));
        end
        @(negedge clk);
        bus.prg_sync_in = 1'b0;
        bus.start_timer = 1'b0;
        bus.time_value  = '0;
        bus.param_sel   = 2'b11;
    endtask

    task automatic start_and_check(input logic [1:0] addr, input int n_sec, input string name);
        drive(1'b0, 2'b11, '0, 1'b1, addr, n_sec);
        check({name, "_expired_low"}, int'(bus.expired), 0);
        check({name, "_loaded"}, int'(bus.remaining), n_sec);
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: pending=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        cyc = 0; total = 0; bad = 0; prev_exp = 1'b0;
        bus.prg_sync_in = 1'b0; bus.param_sel = 2'b11; bus.time_value = '0;
        bus.start_timer = 1'b0; bus.interval_address = 2'b00;
        sys_reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_remaining", int'(bus.remaining), 6);
        check("rst_expired", int'(bus.expired), 0);
        check("rst_tick", int'(bus.tick_1hz), 0);
        check("rst_state", int'(dbg_state), 0);

        // 1: release, BASE runs by itself
        sys_reset_n = 1'b1;
        exp_q.push_back(32'(cyc + 24));
        check("t1_rem_0", int'(bus.remaining), 6);
        for (int k = 1; k <= 6; k++) begin
            repeat (T) @(negedge clk);
            check("t1_remaining", int'(bus.remaining), 6 - k);
            check("t1_tick", int'(bus.tick_1hz), 1);
        end
        @(negedge clk);
        check("t1_tick_after", int'(bus.tick_1hz), 0);
        repeat (6) @(negedge clk);
        check("t1_hold_rem", int'(bus.remaining), 0);
        check("t1_hold_exp", int'(bus.expired), 1);
        check("t1_hold_tick", int'(bus.tick_1hz), 0);
        check("t1_state", int'(dbg_state), 1);
        wait_done(50, "t1");

        // 2: YEL
        start_and_check(2'b10, 2, "t2");
        wait_done(50, "t2");

        // 3: program EXT=9, then a zero write must not change it
        drive(1'b1, 2'b01, 4'd9, 1'b0, 2'b00, 0);
        start_and_check(2'b01, 9, "t3a");
        wait_done(60, "t3a");
        drive(1'b1, 2'b01, 4'd0, 1'b0, 2'b00, 0);
        start_and_check(2'b01, 9, "t3b");
        wait_done(60, "t3b");

        // 5: restart 10 cycles into a BASE count
        start_and_check(2'b00, 6, "t5a");
        repeat (9) @(negedge clk);
        start_and_check(2'b00, 6, "t5b");
        wait_done(60, "t5");

        // 4: same-edge write BASE=5 with start of BASE is forwarded
        drive(1'b1, 2'b00, 4'd5, 1'b1, 2'b00, 5);
        check("t4_loaded", int'(bus.remaining), 5);
        wait_done(40, "t4");

        // address 11 loads BASE; a mid-count write must not disturb the count
        start_and_check(2'b11, 5, "addr3");
        drive(1'b1, 2'b00, 4'd7, 1'b0, 2'b00, 0);
        drive(1'b1, 2'b10, 4'd4, 1'b0, 2'b00, 0);
        wait_done(40, "addr3");
        start_and_check(2'b00, 7, "base7");
        wait_done(40, "base7");
        start_and_check(2'b10, 4, "yel4");
        wait_done(40, "yel4");

        // 6: asynchronous reset while expired with programmed registers
        check("t6_pre_exp", int'(bus.expired), 1);
        @(negedge clk);
        #2 sys_reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_expired", int'(bus.expired), 0);
        check("t6_remaining", int'(bus.remaining), 6);
        check("t6_state", int'(dbg_state), 0);
        @(negedge clk);
        sys_reset_n = 1'b1;
        exp_q.push_back(32'(cyc + 24));
        wait_done(50, "t6_base");
        start_and_check(2'b01, 3, "t6_ext");
        wait_done(30, "t6_ext");
        start_and_check(2'b10, 2, "t6_yel");
        wait_done(30, "t6_yel");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
